div8b_bcd_conv: RTL and testbench

- Sits directly downstream of div_8b and consumes its quot/rem result.
- Captures the quotient and remainder once the divider finishes, then converts each to 3-digit packed BCD using sequential double-dabble (shift-add-3).
- Presents the BCD result with a valid/ack handshake to the display/reporting logic.
- Iterative: one double-dabble step per clock, both operands converted in parallel.

---
 rtl/div8b_bcd_conv_pkg.sv | 14 +
 rtl/div8b_bcd_conv_if.sv | 29 ++
 rtl/div8b_bcd_conv_dd_step.sv | 26 ++
 rtl/div8b_bcd_conv.sv | 96 +++++++++
 tb/tb_div8b_bcd_conv.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/div8b_bcd_conv_pkg.sv
// Shared types and defaults for the divider-result BCD converter.
package div8b_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int W_DEF      = 8;
  localparam int DIGITS_DEF = 3;
  localparam int BCD_W      = 4 * DIGITS_DEF;

endpackage

// File: rtl/div8b_bcd_conv_if.sv
// Handshake bundle between div_8b, the BCD converter and the display side.
interface div8b_bcd_conv_if
  import div8b_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int DIGITS = DIGITS_DEF
);
  localparam int BW = 4 * DIGITS;

  logic          in_valid;
  logic [W-1:0]  in_quot;
  logic [W-1:0]  in_rem;
  logic          in_ready;
  logic          out_valid;
  logic          out_ack;
  logic [BW-1:0] quot_bcd;
  logic [BW-1:0] rem_bcd;
  logic          overrun;

  modport master (
    output in_valid, in_quot, in_rem, out_ack,
    input  in_ready, out_valid, quot_bcd, rem_bcd, overrun
  );

  modport slave (
    input  in_valid, in_quot, in_rem, out_ack,
    output in_ready, out_valid, quot_bcd, rem_bcd, overrun
  );
endinterface

// File: rtl/div8b_bcd_conv_dd_step.sv
// One double-dabble step: add 3 to every BCD nibble >= 5, then shift left by 1.
module bcd_dd_step
  import div8b_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic [4*DIGITS+W-1:0] din,
  output logic [4*DIGITS+W-1:0] dout
);
  localparam int SW = 4 * DIGITS + W;

  logic [SW-1:0] adj;

  // Binary field passes through untouched; only the BCD nibbles get corrected.
  assign adj[W-1:0] = din[W-1:0];

  for (genvar d = 0; d < DIGITS; d++) begin : g_nib
    logic [3:0] nib;
    assign nib = din[W+4*d +: 4];
    assign adj[W+4*d +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  // Top bit never carries a 1 because 10^DIGITS exceeds the binary range.
  assign dout = adj << 1;
endmodule

// File: rtl/div8b_bcd_conv.sv
// Captures div_8b quotient/remainder and converts both to packed BCD,
// one double-dabble step per clock, result offered with valid/ack.
module div8b_bcd_conv
  import div8b_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int DIGITS  = DIGITS_DEF,
  parameter bit EDGE_IN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  div8b_bcd_conv_if.slave  bus
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_t        state, state_nxt;
  logic [SW-1:0] q_sr, r_sr, q_nxt, r_nxt;
  logic [CW-1:0] cnt;
  logic          prev;
  logic          evt;
  logic          last;
  logic [BW-1:0] quot_bcd_q, rem_bcd_q;
  logic          overrun_q;

  // Edge mode: rising edge of the divider's ready level; prev resets to 1 so
  // a ready already high coming out of reset is not mistaken for new data.
  assign evt  = EDGE_IN ? (bus.in_valid & ~prev)
                        : (bus.in_valid & (state == IDLE));
  assign last = (cnt == CW'(W - 1));

  bcd_dd_step #(.W(W), .DIGITS(DIGITS)) u_step_q (.din(q_sr), .dout(q_nxt));
  bcd_dd_step #(.W(W), .DIGITS(DIGITS)) u_step_r (.din(r_sr), .dout(r_nxt));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: capture -> W shift steps -> hold until acknowledged.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (evt)         state_nxt = SHIFT;
      SHIFT:   if (last)        state_nxt = DONE;
      DONE:    if (bus.out_ack) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Datapath: operand capture, shift steps, result latch, edge history, overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_sr       <= '0;
      r_sr       <= '0;
      cnt        <= '0;
      quot_bcd_q <= '0;
      rem_bcd_q  <= '0;
      overrun_q  <= 1'b0;
      prev       <= 1'b1;
    end else begin
      prev <= bus.in_valid;
      // New data while busy is dropped; the in-flight result is kept.
      if (evt && state != IDLE) overrun_q <= 1'b1;
      unique case (state)
        IDLE: if (evt) begin
          q_sr <= {{BW{1'b0}}, bus.in_quot};
          r_sr <= {{BW{1'b0}}, bus.in_rem};
          cnt  <= '0;
        end
        SHIFT: begin
          q_sr <= q_nxt;
          r_sr <= r_nxt;
          cnt  <= cnt + 1'b1;
          if (last) begin
            quot_bcd_q <= q_nxt[SW-1:W];
            rem_bcd_q  <= r_nxt[SW-1:W];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.quot_bcd = quot_bcd_q;
  assign bus.rem_bcd  = rem_bcd_q;
  assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_div8b_bcd_conv.sv
// Directed bench: edge-captured instance for the table and corner sequences,
// strobe-captured instance for back-to-back random divisions.
module tb_div8b_bcd_conv;
  import div8b_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div8b_bcd_conv_if #(.W(8), .DIGITS(3)) if_e ();
  div8b_bcd_conv_if #(.W(8), .DIGITS(3)) if_l ();

  div8b_bcd_conv #(.W(8), .DIGITS(3), .EDGE_IN(1'b1)) u_edge (
    .clk(clk), .rst_n(rst_n), .bus(if_e)
  );
  div8b_bcd_conv #(.W(8), .DIGITS(3), .EDGE_IN(1'b0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .bus(if_l)
  );

  typedef struct {
    logic [7:0]  q;
    logic [7:0]  r;
    logic [11:0] eq;
    logic [11:0] er;
  } vec_t;

  vec_t vecs[5];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One full edge-triggered conversion; an ack pulse mid-shift must be ignored.
  task automatic run_edge(input vec_t v);
    if_e.in_valid = 1'b0;
    step();
    if_e.in_quot  = v.q;
    if_e.in_rem   = v.r;
    if_e.in_valid = 1'b1;
    step();
    chk("busy_after_capture", if_e.in_ready, 1'b0);
    for (int i = 1; i < 8; i++) begin
      if_e.out_ack = (i == 3);
      step();
    end
    if_e.out_ack = 1'b0;
    chk("no_valid_before_w", if_e.out_valid, 1'b0);
    step();
    chk("valid_at_w", if_e.out_valid, 1'b1);
    chk("quot_bcd", if_e.quot_bcd, v.eq);
    chk("rem_bcd", if_e.rem_bcd, v.er);
    chk("no_overrun", if_e.overrun, 1'b0);
    if_e.out_ack = 1'b1;
    step();
    if_e.out_ack = 1'b0;
    chk("ready_after_ack", if_e.in_ready, 1'b1);
    chk("valid_clear_after_ack", if_e.out_valid, 1'b0);
    chk("quot_held_after_ack", if_e.quot_bcd, v.eq);
    if_e.in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{q: 8'd28,  r: 8'd4,   eq: 12'h028, er: 12'h004};
    vecs[1] = '{q: 8'd255, r: 8'd156, eq: 12'h255, er: 12'h156};
    vecs[2] = '{q: 8'd0,   r: 8'd0,   eq: 12'h000, er: 12'h000};
    vecs[3] = '{q: 8'd99,  r: 8'd100, eq: 12'h099, er: 12'h100};
    vecs[4] = '{q: 8'd128, r: 8'd7,   eq: 12'h128, er: 12'h007};

    if_e.in_valid = 1'b1;   // divider ready already high through reset
    if_e.in_quot  = 8'd0;
    if_e.in_rem   = 8'd0;
    if_e.out_ack  = 1'b0;
    if_l.in_valid = 1'b0;
    if_l.in_quot  = 8'd0;
    if_l.in_rem   = 8'd0;
    if_l.out_ack  = 1'b0;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", if_e.in_ready, 1'b1);
    chk("rst_out_valid", if_e.out_valid, 1'b0);
    chk("rst_quot_bcd", if_e.quot_bcd, 12'h000);
    chk("rst_rem_bcd", if_e.rem_bcd, 12'h000);
    chk("rst_overrun", if_e.overrun, 1'b0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("ready_high_no_capture", if_e.in_ready, 1'b1);
    if_e.in_valid = 1'b0;

    foreach (vecs[k]) run_edge(vecs[k]);

    // Second ready edge three cycles into a conversion.
    step();
    if_e.in_quot  = 8'd45;
    if_e.in_rem   = 8'd6;
    if_e.in_valid = 1'b1;
    step();
    if_e.in_valid = 1'b0;
    step();
    step();
    if_e.in_quot  = 8'd77;
    if_e.in_rem   = 8'd77;
    if_e.in_valid = 1'b1;
    step();
    chk("overrun_set", if_e.overrun, 1'b1);
    repeat (4) step();
    chk("ovr_no_valid_early", if_e.out_valid, 1'b0);
    step();
    chk("ovr_valid", if_e.out_valid, 1'b1);
    chk("ovr_quot_first", if_e.quot_bcd, 12'h045);
    chk("ovr_rem_first", if_e.rem_bcd, 12'h006);
    if_e.out_ack = 1'b1;
    step();
    if_e.out_ack = 1'b0;
    chk("ovr_ready_after_ack", if_e.in_ready, 1'b1);
    chk("overrun_sticky", if_e.overrun, 1'b1);

    // Reset at shift step 4 with ready held high throughout.
    if_e.in_valid = 1'b0;
    step();
    if_e.in_quot  = 8'd200;
    if_e.in_rem   = 8'd13;
    if_e.in_valid = 1'b1;
    step();
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_in_ready", if_e.in_ready, 1'b1);
    chk("midrst_out_valid", if_e.out_valid, 1'b0);
    chk("midrst_quot_bcd", if_e.quot_bcd, 12'h000);
    chk("midrst_overrun", if_e.overrun, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_rst_idle", {if_e.in_ready, if_e.out_valid}, 2'b10);
    end
    if_e.in_valid = 1'b0;

    // Strobe-captured instance: valid and ack held high, one result per W+2.
    if_l.out_ack = 1'b1;
    for (int k = 0; k < 10; k++) begin
      int a, b, q, r;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      if (k == 0) b = 0;
      q = (b == 0) ? 255 : a / b;
      r = (b == 0) ? a : a % b;
      chk("lvl_ready", if_l.in_ready, 1'b1);
      if_l.in_quot  = 8'(q);
      if_l.in_rem   = 8'(r);
      if_l.in_valid = 1'b1;
      step();
      chk("lvl_busy", if_l.in_ready, 1'b0);
      repeat (7) step();
      chk("lvl_no_valid_early", if_l.out_valid, 1'b0);
      step();
      chk("lvl_valid", if_l.out_valid, 1'b1);
      chk("lvl_quot_bcd", if_l.quot_bcd, to_bcd(q));
      chk("lvl_rem_bcd", if_l.rem_bcd, to_bcd(r));
      step();
      chk("lvl_valid_drop", if_l.out_valid, 1'b0);
    end
    chk("lvl_overrun", if_l.overrun, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
